// File: rtl/insn_stream_encoder_pkg.sv
// Shared ISA definitions for the instruction stream encoder: opcodes, word formats
// and the loader FSM states.
package insn_stream_encoder_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_RI   = 5'b01011;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_JI  = 3'd2,
    FMT_JII = 3'd3,
    FMT_BAD = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic fmt_e op_format(input logic [4:0] op);
    fmt_e f;
    case (op)
      OP_R:                                     f = FMT_R;
      OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT, OP_RI: f = FMT_I;
      OP_J, OP_JAL, OP_SETX, OP_BEX:            f = FMT_JI;
      OP_JR:                                    f = FMT_JII;
      default:                                  f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/insn_format_encoder.sv
// Pure combinational packer: opcode plus operand fields -> 32-bit ISA word and a legal flag.
module insn_format_encoder
  import insn_stream_encoder_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  shamt_i,
  input  logic [4:0]  aluop_i,
  input  logic [16:0] imm_i,
  input  logic [26:0] target_i,
  output logic        legal_o,
  output logic [31:0] word_o
);

  // Select the word layout from the opcode's format class
  always_comb begin
    legal_o = 1'b0;
    word_o  = 32'd0;
    case (op_format(op_i))
      FMT_R: begin
        legal_o = 1'b1;
        word_o  = {op_i, rd_i, rs_i, rt_i, shamt_i, aluop_i, 2'b00};
      end
      FMT_I: begin
        legal_o = 1'b1;
        word_o  = {op_i, rd_i, rs_i, imm_i};
      end
      FMT_JI: begin
        legal_o = 1'b1;
        word_o  = {op_i, target_i};
      end
      FMT_JII: begin
        legal_o = 1'b1;
        word_o  = {op_i, rd_i, 22'd0};
      end
      default: begin
        legal_o = 1'b0;
        word_o  = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/insn_stream_encoder.sv
// Accepts instruction field bundles, encodes them, buffers them in a small FIFO and
// writes them sequentially into instruction memory from a programmable base address.
module insn_stream_encoder
  import insn_stream_encoder_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] limit_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [4:0]        in_op_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_rs_i,
  input  logic [4:0]        in_rt_i,
  input  logic [4:0]        in_shamt_i,
  input  logic [4:0]        in_aluop_i,
  input  logic [16:0]       in_imm_i,
  input  logic [26:0]       in_target_i,
  input  logic              imem_busy_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              done_o,
  output logic              err_op_o,
  output logic              err_ovf_o,
  output logic [ADDR_W-1:0] word_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] limit_q;
  logic [ADDR_W-1:0] word_count_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_data_q;
  logic              done_q;
  logic              err_op_q;
  logic              err_ovf_q;

  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W:0]    count_q;
  logic [PTR_W:0]    count_d;

  logic              enc_legal_s;
  logic [31:0]       enc_word_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              accept_s;
  logic              push_s;
  logic              bypass_s;
  logic              pop_s;
  logic              fifo_wr_s;
  logic              issue_s;
  logic [31:0]       issue_word_s;
  logic              at_limit_s;

  insn_format_encoder u_fmt (
    .op_i     (in_op_i),
    .rd_i     (in_rd_i),
    .rs_i     (in_rs_i),
    .rt_i     (in_rt_i),
    .shamt_i  (in_shamt_i),
    .aluop_i  (in_aluop_i),
    .imm_i    (in_imm_i),
    .target_i (in_target_i),
    .legal_o  (enc_legal_s),
    .word_o   (enc_word_s)
  );

  // Handshake and write-side steering; an empty FIFO lets a fresh word go straight to imem
  always_comb begin
    fifo_empty_s = (count_q == '0);
    fifo_full_s  = (count_q == FULL_CNT);
    in_ready_o   = (state_q == ST_LOAD) && !fifo_full_s;
    accept_s     = in_valid_i && in_ready_o;
    push_s       = accept_s && enc_legal_s;
    bypass_s     = push_s && fifo_empty_s && !imem_busy_i;
    pop_s        = !fifo_empty_s && !imem_busy_i;
    fifo_wr_s    = push_s && !bypass_s;
    issue_s      = pop_s || bypass_s;
    issue_word_s = fifo_empty_s ? enc_word_s : fifo_q[rd_ptr_q];
    at_limit_s   = (limit_q != '0) && (word_count_q == limit_q);
  end

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({fifo_wr_s, pop_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers and occupancy; reset discards any queued words
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (fifo_wr_s) begin
      fifo_q[wr_ptr_q] <= enc_word_s;
    end
  end

  // Program FSM plus registered memory write port and status flags
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      limit_q      <= '0;
      word_count_q <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= 32'd0;
      done_q       <= 1'b0;
      err_op_q     <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q      <= ST_LOAD;
            addr_q       <= base_addr_i;
            limit_q      <= limit_i;
            word_count_q <= '0;
            done_q       <= 1'b0;
            err_op_q     <= 1'b0;
            err_ovf_q    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            if (!enc_legal_s) begin
              err_op_q <= 1'b1;
            end
            if (in_last_i) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (fifo_empty_s) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Words past the limit are consumed but never written
      if (issue_s) begin
        if (at_limit_s) begin
          err_ovf_q <= 1'b1;
        end else begin
          imem_we_q    <= 1'b1;
          imem_addr_q  <= addr_q;
          imem_data_q  <= issue_word_s;
          addr_q       <= addr_q + ADDR_W'(1);
          word_count_q <= word_count_q + ADDR_W'(1);
        end
      end
    end
  end

  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_data_o  = imem_data_q;
  assign done_o       = done_q;
  assign err_op_o     = err_op_q;
  assign err_ovf_o    = err_ovf_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_insn_stream_encoder.sv
// Scoreboard bench for insn_stream_encoder: directed scenarios plus randomized programs
// checked against a field-level reference model.
module tb_insn_stream_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = 12'd0;
  logic [11:0] limit = 12'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [4:0]  in_op = 5'd0, in_rd = 5'd0, in_rs = 5'd0, in_rt = 5'd0;
  logic [4:0]  in_shamt = 5'd0, in_aluop = 5'd0;
  logic [16:0] in_imm = 17'd0;
  logic [26:0] in_target = 27'd0;
  logic        imem_busy = 1'b0;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic        done, err_op, err_ovf;
  logic [11:0] word_count;

  int n_vec = 0;
  int n_err = 0;

  logic [43:0] exp_q[$];
  int          m_addr, m_count, m_limit;
  logic        m_err_op, m_err_ovf;
  logic        rand_busy = 1'b0;
  logic        force_busy = 1'b0;

  insn_stream_encoder #(.ADDR_W(12), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .base_addr_i(base_addr), .limit_i(limit),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last), .in_op_i(in_op),
    .in_rd_i(in_rd), .in_rs_i(in_rs), .in_rt_i(in_rt), .in_shamt_i(in_shamt),
    .in_aluop_i(in_aluop), .in_imm_i(in_imm), .in_target_i(in_target),
    .imem_busy_i(imem_busy), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_data_o(imem_data), .done_o(done), .err_op_o(err_op), .err_ovf_o(err_ovf),
    .word_count_o(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    imem_busy = rand_busy ? ($urandom_range(0, 3) == 0) : force_busy;
  end

  // Monitor: every memory write must match the oldest expected (addr, data)
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", imem_addr, imem_data);
      end else begin
        logic [43:0] e;
        e = exp_q.pop_front();
        if ({imem_addr, imem_data} !== e) begin
          n_err++;
          $display("FAIL imem_write: got addr=%h data=%h, expected addr=%h data=%h",
                   imem_addr, imem_data, e[43:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input int op);
    return op inside {0, 1, 2, 3, 4, 5, 6, 7, 8, 11, 21, 22};
  endfunction

  // Reference encoding built from field arithmetic
  function automatic longint ref_word(input int op, rd, rs, rt, sh, alu, imm, tgt);
    longint w;
    w = longint'(op) * 134217728;
    if (op == 0)
      w += rd * 4194304 + rs * 131072 + rt * 4096 + sh * 128 + alu * 4;
    else if (op inside {2, 5, 6, 7, 8, 11})
      w += rd * 4194304 + rs * 131072 + imm;
    else if (op inside {1, 3, 21, 22})
      w += tgt;
    else
      w += rd * 4194304;
    return w % 64'h1_0000_0000;
  endfunction

  task automatic model_accept(input int op, rd, rs, rt, sh, alu, imm, tgt);
    longint w;
    if (!is_legal(op)) begin
      m_err_op = 1'b1;
    end else if (m_limit != 0 && m_count == m_limit) begin
      m_err_ovf = 1'b1;
    end else begin
      w = ref_word(op, rd, rs, rt, sh, alu, imm, tgt);
      exp_q.push_back({12'(m_addr), 32'(w)});
      m_addr  = (m_addr + 1) % 4096;
      m_count = m_count + 1;
    end
  endtask

  task automatic pulse_start(input int b, input int l, input bit apply);
    @(negedge clk);
    start = 1'b1; base_addr = 12'(b); limit = 12'(l);
    @(posedge clk); #1;
    start = 1'b0;
    if (apply) begin
      m_addr = b; m_limit = l; m_count = 0; m_err_op = 1'b0; m_err_ovf = 1'b0;
    end
  endtask

  task automatic send(input int op, rd, rs, rt, sh, alu, imm, tgt, input bit last);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_last = last; in_op = 5'(op); in_rd = 5'(rd); in_rs = 5'(rs);
    in_rt = 5'(rt); in_shamt = 5'(sh); in_aluop = 5'(alu); in_imm = 17'(imm); in_target = 27'(tgt);
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      check("in_ready_timeout", 0, 1);
    end else begin
      model_accept(op, rd, rs, rt, sh, alu, imm, tgt);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_rand(input bit allow_bad, input bit last);
    int op;
    op = $urandom_range(0, 31);
    if (allow_bad) begin
      if ($urandom_range(0, 7) != 0) while (!is_legal(op)) op = $urandom_range(0, 31);
    end else begin
      while (!is_legal(op)) op = $urandom_range(0, 31);
    end
    send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 131071),
         $urandom_range(0, 134217727), last);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_count"}, word_count, m_count);
    check({tag, "_err_op"}, err_op, m_err_op);
    check({tag, "_err_ovf"}, err_ovf, m_err_ovf);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr_data"}, {imem_addr, imem_data}, 0);
    check({tag, "_flags"}, {in_ready, done, err_op, err_ovf}, 0);
    check({tag, "_count"}, word_count, 0);
  endtask

  initial begin
    m_addr = 0; m_count = 0; m_limit = 0; m_err_op = 1'b0; m_err_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // 1: single addi
    pulse_start(12'h010, 0, 1'b1);
    send(5, 1, 0, 0, 0, 0, 5, 0, 1'b1);
    wait_done("t1");

    // 2: R add then j; a start during LOAD is ignored
    pulse_start(12'h123, 0, 1'b1);
    send(0, 3, 1, 2, 0, 0, 0, 0, 1'b0);
    pulse_start(12'h300, 0, 1'b0);
    send(1, 0, 0, 0, 0, 0, 0, 27'h100, 1'b1);
    wait_done("t2");

    // 3: illegal opcode between legal words
    pulse_start(12'h040, 0, 1'b1);
    send(7, 2, 3, 0, 0, 0, 17'h1FFFF, 0, 1'b0);
    send(31, 1, 1, 1, 1, 1, 1, 1, 1'b0);
    send(4, 9, 0, 0, 0, 0, 0, 0, 1'b1);
    wait_done("t3");

    // 4: memory busy while streaming six words into a depth-4 FIFO
    pulse_start(12'h200, 0, 1'b1);
    force_busy = 1'b1;
    @(negedge clk);
    repeat (4) send_rand(1'b0, 1'b0);
    @(negedge clk);
    check("t4_full_in_ready", in_ready, 0);
    repeat (6) @(negedge clk);
    force_busy = 1'b0;
    send_rand(1'b0, 1'b0);
    send_rand(1'b0, 1'b1);
    wait_done("t4");

    // 5: limit overflow, then address wrap
    pulse_start(12'h080, 2, 1'b1);
    repeat (2) send_rand(1'b0, 1'b0);
    send_rand(1'b0, 1'b1);
    wait_done("t5a");
    pulse_start(12'hFFF, 0, 1'b1);
    send_rand(1'b0, 1'b0);
    send_rand(1'b0, 1'b1);
    wait_done("t5b");

    // 6: reset with words still queued
    pulse_start(12'h500, 0, 1'b1);
    force_busy = 1'b1;
    @(negedge clk);
    repeat (3) send_rand(1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    force_busy = 1'b0;
    @(negedge clk);
    check_reset_vals("t6");
    repeat (6) @(negedge clk);
    check("t6_no_write", imem_we, 0);

    // Randomized programs with random busy, gaps, illegal ops and limits
    rand_busy = 1'b1;
    for (int p = 0; p < 6; p++) begin
      int nw;
      nw = $urandom_range(3, 12);
      pulse_start($urandom_range(0, 4095), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0, 1'b1);
      for (int k = 0; k < nw; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_rand(1'b1, k == nw - 1);
      end
      wait_done("rand");
    end
    rand_busy = 1'b0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
